// File: rtl/adc_multi_avg_if.sv
// XADC-side DRP handshake and per-channel averaged result bundle for adc_multi_avg.
// The slave modport is the averaging block; the master modport is the XADC/driver side.
interface adc_multi_avg_if #(
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 7
);
  logic                    eoc_in;
  logic [4:0]              channel_in;
  logic                    drdy_in;
  logic [15:0]             do_in;
  logic                    den_out;
  logic [6:0]              daddr_out;
  logic [NUM_CH*OUT_W-1:0] avg_value;
  logic [NUM_CH-1:0]       avg_valid;
  logic [NUM_CH-1:0]       above;
  logic                    drp_timeout;
  logic                    overrun;

  modport slave (
    input  eoc_in, channel_in, drdy_in, do_in,
    output den_out, daddr_out, avg_value, avg_valid, above, drp_timeout, overrun
  );

  modport master (
    output eoc_in, channel_in, drdy_in, do_in,
    input  den_out, daddr_out, avg_value, avg_valid, above, drp_timeout, overrun
  );
endinterface

// File: rtl/adc_multi_avg.sv
// Reads XADC aux-channel samples over DRP after each end-of-conversion and keeps a
// per-channel running average of 2**AVG_LOG2 samples with a hysteresis threshold flag.
module adc_multi_avg #(
  parameter int NUM_CH   = 2,
  parameter int CH_BASE  = 22,
  parameter int OUT_W    = 7,
  parameter int AVG_LOG2 = 2,
  parameter int TH_HI    = 80,
  parameter int TH_LO    = 48,
  parameter int TIMEOUT  = 15
) (
  input logic            clk,
  input logic            reset_n,
  adc_multi_avg_if.slave bus
);

  localparam int ACC_W    = 12 + AVG_LOG2;
  localparam int CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TIMER_W  = $clog2(TIMEOUT + 1);

  localparam logic [4:0]         CH_LO      = 5'(CH_BASE);
  localparam logic [4:0]         CH_HI      = 5'(CH_BASE + NUM_CH - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [OUT_W-1:0]   TH_HI_L    = OUT_W'(TH_HI);
  localparam logic [OUT_W-1:0]   TH_LO_L    = OUT_W'(TH_LO);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RDY, ACCUM} state_t;

  state_t                  r_state;
  logic                    r_eocD;
  logic [CH_IDX_W-1:0]     r_chIdx;
  logic [11:0]             r_sample;
  logic [TIMER_W-1:0]      r_timer;
  logic [ACC_W-1:0]        r_acc [NUM_CH];
  logic [CNT_W-1:0]        r_cnt [NUM_CH];
  logic                    r_den;
  logic [6:0]              r_daddr;
  logic [NUM_CH*OUT_W-1:0] r_avg;
  logic [NUM_CH-1:0]       r_avgValid;
  logic [NUM_CH-1:0]       r_above;
  logic                    r_drpTimeout;
  logic                    r_overrun;

  logic                    w_edge;
  logic                    w_inRange;
  logic [CH_IDX_W-1:0]     w_chIdx;
  logic [ACC_W-1:0]        w_accTotal;
  logic [11:0]             w_mean;
  logic [OUT_W-1:0]        w_newAvg;
  logic                    w_wrap;

  assign w_edge     = bus.eoc_in & ~r_eocD;
  assign w_inRange  = (bus.channel_in >= CH_LO) && (bus.channel_in <= CH_HI);
  assign w_chIdx    = CH_IDX_W'(bus.channel_in - CH_LO);
  // The running total already includes the sample being accumulated this cycle.
  assign w_accTotal = r_acc[r_chIdx] + ACC_W'(r_sample);
  assign w_mean     = 12'(w_accTotal >> AVG_LOG2);
  assign w_newAvg   = OUT_W'(w_mean >> (12 - OUT_W));
  assign w_wrap     = (r_cnt[r_chIdx] == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_eocD       <= 1'b0;
      r_chIdx      <= '0;
      r_sample     <= '0;
      r_timer      <= '0;
      r_den        <= 1'b0;
      r_daddr      <= '0;
      r_avg        <= '0;
      r_avgValid   <= '0;
      r_above      <= '0;
      r_drpTimeout <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_eocD     <= bus.eoc_in;
      r_den      <= 1'b0;
      r_avgValid <= '0;
      if (w_edge && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_edge && w_inRange) begin
            r_chIdx <= w_chIdx;
            r_daddr <= {2'b00, bus.channel_in};
            r_den   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          r_timer <= '0;
          r_state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (bus.drdy_in) begin
            r_sample <= bus.do_in[15:4];
            r_state  <= ACCUM;
          end else if (r_timer == TIMER_LAST) begin
            r_drpTimeout <= 1'b1;
            r_daddr      <= '0;
            r_state      <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ACCUM: begin
          // Between thresholds the flag keeps its previous value.
          if (w_wrap) begin
            r_avg[r_chIdx*OUT_W +: OUT_W] <= w_newAvg;
            r_avgValid[r_chIdx]           <= 1'b1;
            if (w_newAvg >= TH_HI_L) begin
              r_above[r_chIdx] <= 1'b1;
            end else if (w_newAvg <= TH_LO_L) begin
              r_above[r_chIdx] <= 1'b0;
            end
            r_acc[r_chIdx] <= '0;
            r_cnt[r_chIdx] <= '0;
          end else begin
            r_acc[r_chIdx] <= w_accTotal;
            r_cnt[r_chIdx] <= r_cnt[r_chIdx] + 1'b1;
          end
          r_daddr <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.den_out     = r_den;
  assign bus.daddr_out   = r_daddr;
  assign bus.avg_value   = r_avg;
  assign bus.avg_valid   = r_avgValid;
  assign bus.above       = r_above;
  assign bus.drp_timeout = r_drpTimeout;
  assign bus.overrun     = r_overrun;

endmodule

// File: doc/adc_multi_avg.md
ADC_MULTI_AVG -- requirements
Module: adc_multi_avg

Parameters
REQ-001 NUM_CH, 2, number of consecutive XADC aux channels serviced (1..8).
REQ-002 CH_BASE, 22, XADC channel address of channel index 0 (aux6 = 22; CH_BASE+NUM_CH-1 <= 31).
REQ-003 OUT_W, 7, output resolution per channel in bits (1..12).
REQ-004 AVG_LOG2, 2, log2 of the number of samples averaged per result (0..4).
REQ-005 TH_HI, 80, hysteresis set threshold in OUT_W units.
REQ-006 TH_LO, 48, hysteresis clear threshold in OUT_W units (TH_LO < TH_HI).
REQ-007 TIMEOUT, 15, maximum clocks waited for drdy_in after a DRP read request.

Interface
REQ-008 clk  in  1  single system clock; all logic on its rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 eoc_in  in  1  XADC end-of-conversion.
REQ-011 channel_in  in  5  XADC channel_out.
REQ-012 drdy_in  in  1  XADC DRP data ready.
REQ-013 do_in  in  16  XADC DRP read data; bits [15:4] hold the 12-bit sample.
REQ-014 den_out  out  1  DRP enable pulse to XADC.
REQ-015 daddr_out  out  7  DRP address ({2'b00, latched channel}).
REQ-016 avg_value  out  NUM_CH*OUT_W  averaged result; channel i occupies bits [i*OUT_W +: OUT_W].
REQ-017 avg_valid  out  NUM_CH  one-cycle pulse per channel when its avg_value updates.
REQ-018 above  out  NUM_CH  per-channel hysteresis flag.
REQ-019 drp_timeout  out  1  sticky flag: a DRP read timed out.
REQ-020 overrun  out  1  sticky flag: an EOC edge was dropped while busy.

Function
REQ-021 The block SHALL detect the eoc_in rising edge with one register (eoc_d); edge = eoc_in & ~eoc_d.
REQ-022 FSM states SHALL be IDLE, REQ, WAIT_RDY, ACCUM.
REQ-023 In IDLE, on an edge with channel_in in [CH_BASE, CH_BASE+NUM_CH-1], the block SHALL latch the channel and go to REQ; out-of-range channels SHALL be ignored (no DRP access).
REQ-024 In REQ, den_out SHALL be high for exactly one cycle with daddr_out = latched channel; the next state SHALL be WAIT_RDY.
REQ-025 daddr_out SHALL hold the latched channel until the FSM returns to IDLE.
REQ-026 In WAIT_RDY, when drdy_in is high, the block SHALL capture do_in[15:4] and go to ACCUM.
REQ-027 If drdy_in is not seen within TIMEOUT cycles after den_out, the block SHALL discard the request, set drp_timeout, and return to IDLE.
REQ-028 In ACCUM, the block SHALL add the sample to that channel's accumulator (12+AVG_LOG2 bits) and increment that channel's sample counter (AVG_LOG2 bits); the next state SHALL be IDLE.
REQ-029 When a channel's counter wraps, ACCUM SHALL load avg_value[i] = (acc_total >> AVG_LOG2)[11:12-OUT_W]; acc_total includes the current sample.
REQ-030 In the same cycle, ACCUM SHALL pulse avg_valid[i], update above[i], and clear the accumulator.
REQ-031 Latency: avg_valid[i] is high in the cycle after the clock edge where the final drdy_in is sampled, plus one (the ACCUM cycle).
REQ-032 above[i] SHALL be set when the new avg >= TH_HI, cleared when the new avg <= TH_LO, and held otherwise.
REQ-033 An eoc edge outside IDLE SHALL be dropped and SHALL set overrun.
REQ-034 Each channel SHALL accumulate independently; interleaved channels SHALL NOT corrupt each other.
REQ-035 With AVG_LOG2=0, every sample SHALL produce a result.

Reset
REQ-036 On reset_n low, the block SHALL immediately force:
  - FSM to IDLE; eoc_d, den_out, daddr_out to 0;
  - all accumulators, counters, avg_value, avg_valid, above to 0;
  - drp_timeout and overrun to 0.
REQ-037 Reset mid-operation SHALL abort any pending DRP read and discard partial averages.
REQ-038 If eoc_in is high at the first edge after reset release, that edge SHALL count as a rising edge.

Verification (defaults unless noted)
REQ-039 Four ch22 conversions, each with do_in=16'h8000 -> avg_valid[0] pulses once; avg_value[0]=64; above[0]=0.
REQ-040 ch22 samples 0x000, 0x000, 0xFFF, 0xFFF -> avg_value[0]=63; interleaved ch23 samples 0xFFF x4 -> avg_value[1]=127, above[1]=1.
REQ-041 Successive ch22 averages 127, then 64, then 32 -> above[0] = 1, then 1, then 0.
REQ-042 den_out issued and drdy_in held low for 15 cycles -> drp_timeout=1, FSM back in IDLE, no avg_valid, counter unchanged.
REQ-043 Two cases:
  - eoc edge with channel_in=0 -> no den_out, no state change;
  - eoc edge while in WAIT_RDY -> overrun=1.
REQ-044 reset_n pulsed low after 2 of 4 samples, then 4 samples of 0x800 -> avg_value=64 (the earlier 2 samples are discarded); all flags 0 after reset.
